// File: rtl/cas_loader.sv
// cas_loader: parses a SYSTEM-format .CAS download into Z80 memory writes and an execute address.
module cas_loader #(
   parameter logic [7:0] SYNC_BYTE  = 8'h66,
   parameter logic [7:0] SYS_MARK   = 8'h55,
   parameter int         NAME_LEN   = 6,
   parameter int         MAX_LEADER = 1024
) (
   input  logic        clk_sys,
   input  logic        power,
   input  logic        dn_go,
   input  logic        dn_wr,
   input  logic [24:0] dn_addr,
   input  logic [7:0]  dn_data,
   input  logic        mem_busy,
   output logic        dn_wait,
   output logic        loader_download,
   output logic        loader_wr,
   output logic [15:0] loader_addr,
   output logic [7:0]  loader_data,
   output logic [15:0] execute_addr,
   output logic        execute_enable,
   output logic [3:0]  err,
   output logic [7:0]  block_cnt
);
   typedef enum logic [3:0] {
      S_IDLE, S_LEADER, S_MARK, S_NAME, S_BTYPE, S_COUNT, S_ALO,
      S_AHI, S_DATA, S_CSUM, S_EXLO, S_EXHI, S_DONE, S_ERR
   } state_t;
   localparam int LW = $clog2(MAX_LEADER + 1);
   localparam logic [LW-1:0] LEAD_LAST = LW'(MAX_LEADER - 1);
   localparam logic [7:0] NAME_LAST = 8'(NAME_LEN - 1);
   state_t        r_state, w_next, w_cur;
   logic          r_go, r_pend, r_arm, r_exec;
   logic [LW-1:0] r_lead, w_lead;
   logic [7:0]    r_name, r_csum, r_blk, r_wr_data;
   logic [8:0]    r_len;
   logic [15:0]   r_ptr, r_wr_addr, r_exec_addr;
   logic [24:0]   r_fcnt, w_fcnt;
   logic [3:0]    r_err, w_err_set;
   logic          w_rise, w_fall, w_byte, w_drop, w_acc, w_data;

   assign loader_download = r_go;
   assign loader_addr     = r_wr_addr;
   assign loader_data     = r_wr_data;
   assign execute_addr    = r_exec_addr;
   assign execute_enable  = r_exec;
   assign err             = r_err;
   assign block_cnt       = r_blk;

   always_ff @(posedge clk_sys or negedge power)
      if (!power) r_state <= S_IDLE;
      else r_state <= w_next;

   always_comb begin
      w_next = w_cur;
      if (w_fall) w_next = (r_state == S_ERR) ? S_ERR : S_IDLE;
      else if (w_acc)
         case (w_cur)
            S_LEADER: w_next = (dn_data == SYNC_BYTE) ? S_MARK : (w_lead == LEAD_LAST) ? S_ERR : S_LEADER;
            S_MARK:   w_next = (dn_data == SYS_MARK) ? S_NAME : S_ERR;
            S_NAME:   w_next = (r_name == NAME_LAST) ? S_BTYPE : S_NAME;
            S_BTYPE:  w_next = (dn_data == 8'h3C) ? S_COUNT : (dn_data == 8'h78) ? S_EXLO : S_ERR;
            S_COUNT:  w_next = S_ALO;
            S_ALO:    w_next = S_AHI;
            S_AHI:    w_next = S_DATA;
            S_DATA:   w_next = (r_len == 9'd1) ? S_CSUM : S_DATA;
            S_CSUM:   w_next = S_BTYPE;
            S_EXLO:   w_next = S_EXHI;
            S_EXHI:   w_next = S_DONE;
            default:  w_next = w_cur;
         endcase
   end

   // a restart on dn_go rise takes effect in the same cycle, so its byte is parsed as leader
   always_comb begin
      w_rise       = dn_go & ~r_go;
      w_fall       = ~dn_go & r_go;
      w_cur        = w_rise ? S_LEADER : r_state;
      w_lead       = w_rise ? '0 : r_lead;
      w_fcnt       = w_rise ? '0 : r_fcnt;
      w_byte       = dn_wr & dn_go;
      w_drop       = w_byte & r_pend & ~w_rise;
      w_acc        = w_byte & ~w_drop;
      w_data       = w_acc & (w_cur == S_DATA);
      w_err_set[0] = w_acc & (w_cur == S_CSUM) & (dn_data != r_csum);
      w_err_set[1] = w_acc & (((w_cur == S_LEADER) & (dn_data != SYNC_BYTE) & (w_lead == LEAD_LAST))
                     | ((w_cur == S_MARK) & (dn_data != SYS_MARK)));
      w_err_set[2] = (w_acc & (w_cur == S_BTYPE) & (dn_data != 8'h3C) & (dn_data != 8'h78))
                     | (w_fall & !(r_state inside {S_IDLE, S_DONE, S_ERR}))
                     | (w_byte & (dn_addr != w_fcnt));
      w_err_set[3] = w_drop;
      loader_wr    = r_pend & ~mem_busy;
      dn_wait      = r_pend;
   end

   always_ff @(posedge clk_sys or negedge power)
      if (!power) begin
         r_go        <= 1'b0;
         r_pend      <= 1'b0;
         r_arm       <= 1'b0;
         r_exec      <= 1'b0;
         r_lead      <= '0;
         r_name      <= 8'd0;
         r_csum      <= 8'd0;
         r_blk       <= 8'd0;
         r_wr_data   <= 8'd0;
         r_len       <= 9'd0;
         r_ptr       <= 16'd0;
         r_wr_addr   <= 16'd0;
         r_exec_addr <= 16'd0;
         r_fcnt      <= 25'd0;
         r_err       <= 4'd0;
      end else begin
         r_go   <= dn_go;
         r_err  <= (w_rise ? 4'd0 : r_err) | w_err_set;
         r_blk  <= w_rise ? 8'd0 : (w_acc && w_cur == S_CSUM && r_blk != 8'hFF) ? r_blk + 8'd1 : r_blk;
         r_fcnt <= w_byte ? w_fcnt + 25'd1 : w_fcnt;
         r_lead <= (w_acc && w_cur == S_LEADER) ? w_lead + LW'(1) : w_lead;
         r_name <= (w_cur == S_NAME) ? r_name + {7'd0, w_acc} : 8'd0;
         r_pend <= w_data | (r_pend & mem_busy);
         r_arm  <= w_fall & (r_state == S_DONE) & (r_err == 4'd0);
         r_exec <= r_arm;
         if (w_rise) r_csum <= 8'd0;
         if (w_data) begin
            r_wr_addr <= r_ptr;
            r_wr_data <= dn_data;
         end
         if (w_acc)
            case (w_cur)
               S_COUNT: r_len <= {dn_data == 8'd0, dn_data};
               S_ALO: begin
                  r_ptr[7:0] <= dn_data;
                  r_csum     <= dn_data;
               end
               S_AHI: begin
                  r_ptr[15:8] <= dn_data;
                  r_csum      <= r_csum + dn_data;
               end
               S_DATA: begin
                  r_ptr  <= r_ptr + 16'd1;
                  r_csum <= r_csum + dn_data;
                  r_len  <= r_len - 9'd1;
               end
               S_EXLO:  r_exec_addr[7:0]  <= dn_data;
               S_EXHI:  r_exec_addr[15:8] <= dn_data;
               default: ;
            endcase
      end
endmodule

// File: tb/tb_cas_loader.sv
// tb_cas_loader: scoreboard bench for cas_loader; expected writes are queued as data bytes are sent.
module tb_cas_loader;
   logic        clk_sys = 0, power = 0, dn_go = 0, dn_wr = 0, mem_busy = 0;
   logic [24:0] dn_addr = '0;
   logic [7:0]  dn_data = '0;
   logic        dn_wait, loader_download, loader_wr, execute_enable;
   logic [15:0] loader_addr, execute_addr;
   logic [7:0]  loader_data, block_cnt;
   logic [3:0]  err;
   int errors = 0, checks = 0, n_exec = 0, faddr = 0;
   typedef struct packed {logic [15:0] a; logic [7:0] d;} wr_t;
   wr_t q[$];
   wr_t m_e;

   cas_loader dut (
      .clk_sys(clk_sys), .power(power), .dn_go(dn_go), .dn_wr(dn_wr), .dn_addr(dn_addr),
      .dn_data(dn_data), .mem_busy(mem_busy), .dn_wait(dn_wait), .loader_download(loader_download),
      .loader_wr(loader_wr), .loader_addr(loader_addr), .loader_data(loader_data),
      .execute_addr(execute_addr), .execute_enable(execute_enable), .err(err), .block_cnt(block_cnt)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk_sys) begin
      if (execute_enable) n_exec++;
      if (loader_wr) begin
         if (q.size() == 0) check("wr_unexpected", {loader_addr, loader_data}, 0);
         else begin
            m_e = q.pop_front();
            check("wr_addr", loader_addr, m_e.a);
            check("wr_data", loader_data, m_e.d);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [7:0] b);
      int n = 0;
      while (dn_wait && n < 50) begin
         @(posedge clk_sys); #1;
         n++;
      end
      if (n == 50) check("dn_wait_timeout", dn_wait, 0);
      dn_wr = 1; dn_data = b; dn_addr = 25'(faddr); faddr++;
      @(posedge clk_sys); #1;
      dn_wr = 0;
      @(posedge clk_sys); #1;
   endtask

   task automatic send_data(input logic [15:0] a, input logic [7:0] d);
      q.push_back('{a, d});
      send(d);
   endtask

   task automatic start_dl;
      dn_go = 1;
      faddr = 0;
   endtask

   task automatic send_hdr;
      string s = "PROG  ";
      for (int i = 0; i < 10; i++) send(8'h00);
      send(8'h66);
      send(8'h55);
      for (int i = 0; i < 6; i++) send(s[i]);
   endtask

   task automatic send_block(input logic [15:0] a, input int n, input logic [7:0] seed,
                             input logic [7:0] step, input logic bad);
      logic [7:0] cs, d;
      cs = a[7:0] + a[15:8];
      send(8'h3C); send(8'(n)); send(a[7:0]); send(a[15:8]);
      for (int i = 0; i < n; i++) begin
         d = seed + 8'(i) * step;
         cs = cs + d;
         send_data(a + 16'(i), d);
      end
      send(bad ? 8'h00 : cs);
   endtask

   task automatic send_exec(input logic [15:0] a);
      send(8'h78); send(a[7:0]); send(a[15:8]);
   endtask

   task automatic finish_dl(input logic ex);
      int n0;
      n0 = n_exec;
      dn_go = 0;
      @(negedge clk_sys); check("ld_hold", loader_download, 1);
      @(negedge clk_sys); check("ld_fall", loader_download, 0); check("ex_early", execute_enable, 0);
      @(negedge clk_sys); check("ex_pulse", execute_enable, ex);
      @(negedge clk_sys); check("ex_end", execute_enable, 0);
      check("ex_count", n_exec - n0, ex);
      @(posedge clk_sys); #1;
   endtask

   initial begin
      repeat (2) @(posedge clk_sys);
      #1;
      check("rst_outs", {dn_wait, loader_download, loader_wr, loader_addr, loader_data,
                         execute_addr, execute_enable, err, block_cnt}, 0);
      power = 1;
      @(posedge clk_sys); #1;
      // nominal load, first leader byte coincides with dn_go rise
      start_dl; send_hdr; send_block(16'h5800, 3, 8'hAA, 8'h11, 0); send_exec(16'h5800);
      check("nom_q", q.size(), 0); check("nom_blk", block_cnt, 1);
      check("nom_err", err, 0); check("nom_exa", execute_addr, 16'h5800);
      finish_dl(1);
      // 256-byte block wrapping the address
      start_dl; send_hdr; send_block(16'hFFF0, 256, 8'h00, 8'h01, 0); send_exec(16'h1234);
      check("c00_q", q.size(), 0); check("c00_blk", block_cnt, 1); check("c00_err", err, 0);
      check("c00_exa", execute_addr, 16'h1234); check("c00_len", dut.r_len, 0);
      finish_dl(1);
      // bad checksum
      start_dl; send_hdr; send_block(16'h5800, 3, 8'hAA, 8'h11, 1); send_exec(16'h5800);
      check("bcs_q", q.size(), 0); check("bcs_err", err, 4'b0001); check("bcs_blk", block_cnt, 1);
      finish_dl(0);
      // mem_busy stall with an injected byte
      start_dl; send_hdr; send(8'h3C); send(8'h03); send(8'h00); send(8'h58);
      q.push_back('{16'h5800, 8'hAA});
      mem_busy = 1; dn_wr = 1; dn_data = 8'hAA; dn_addr = 25'(faddr); faddr++;
      @(posedge clk_sys); #1;
      dn_wr = 0;
      for (int k = 1; k <= 4; k++) begin
         if (k == 2) begin
            dn_wr = 1; dn_data = 8'hEE; dn_addr = 25'(faddr); faddr++;
         end
         @(negedge clk_sys);
         check("busy_wait", dn_wait, 1); check("busy_nowr", loader_wr, 0);
         @(posedge clk_sys); #1;
         dn_wr = 0;
      end
      mem_busy = 0;
      @(negedge clk_sys);
      check("busy_wr", loader_wr, 1); check("busy_drop", err[3], 1);
      @(posedge clk_sys); #1;
      send_data(16'h5801, 8'hBB); send_data(16'h5802, 8'hCC);
      send(8'h58 + 8'hAA + 8'hBB + 8'hCC); send_exec(16'h5800);
      check("busy_q", q.size(), 0); check("busy_err", err, 4'b1000); check("busy_blk", block_cnt, 1);
      finish_dl(0);
      // truncation in DATA
      start_dl; send_hdr; send(8'h3C); send(8'h03); send(8'h00); send(8'h58);
      send_data(16'h5800, 8'hAA);
      finish_dl(0);
      check("trn_err", err, 4'b0100); check("trn_idle", dut.r_state, 0);
      start_dl;
      @(posedge clk_sys); #1;
      @(negedge clk_sys); check("trn_clr", err, 0);
      dn_go = 0;
      repeat (3) @(posedge clk_sys);
      #1;
      // leader length limit
      start_dl;
      for (int i = 0; i < 1023; i++) send(8'h00);
      check("ldr_ok", err, 0);
      send(8'h00);
      check("ldr_ovf", err, 4'b0010);
      send(8'h66);
      check("ldr_err_hold", err, 4'b0010);
      finish_dl(0);
      // asynchronous reset with a write pending
      start_dl; send_hdr; send(8'h3C); send(8'h03); send(8'h00); send(8'h58);
      mem_busy = 1;
      send_data(16'h5800, 8'hAA);
      check("rst_pend", dn_wait, 1);
      #2 power = 0;
      #1 check("rst_async", {dn_wait, loader_download, loader_wr, loader_addr, loader_data,
                             execute_addr, execute_enable, err, block_cnt}, 0);
      q.delete();
      mem_busy = 0; dn_go = 0;
      repeat (3) begin
         @(negedge clk_sys); check("rst_nowr", loader_wr, 0);
      end
      @(posedge clk_sys); #1;
      power = 1;
      @(negedge clk_sys); check("rst_idle", dut.r_state, 0);
      @(posedge clk_sys); #1;
      start_dl; send_hdr; send_block(16'h4000, 3, 8'h10, 8'h22, 0); send_exec(16'h4000);
      check("rst2_err", err, 0); check("rst2_blk", block_cnt, 1); check("rst2_exa", execute_addr, 16'h4000);
      finish_dl(1);
      check("final_q", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
